// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the MEM-stage read cache and its SRAM sequencer:
//   address-space constants, derived field widths, the controller state
//   enum and the address decode helper.
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam logic [31:0] MEM_BASE = 32'd1024;  // byte base of the data space
  localparam int unsigned SETS     = 64;
  localparam int unsigned ADDR_W   = 19;        // byte address width of the SRAM
  localparam int unsigned INDEX_W  = $clog2(SETS);
  localparam int unsigned TAG_W    = ADDR_W - 3 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL0 = 2'd1,
    FILL1 = 2'd2,
    WRITE = 2'd3
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               word;
  } addr_dec_t;

  // Only bits [ADDR_W-1:2] of the byte address reach the cache fields. The
  // borrow of a subtraction only propagates upwards, so subtracting the
  // matching slice of MEM_BASE gives the same fields as a full 32-bit subtract.
  function automatic addr_dec_t decode(input logic [ADDR_W-1:2] word_addr);
    logic [ADDR_W-1:2] rel;
    addr_dec_t         d;
    rel     = word_addr - MEM_BASE[ADDR_W-1:2];
    d.word  = rel[2];
    d.index = rel[2+INDEX_W:3];
    d.tag   = rel[ADDR_W-1:3+INDEX_W];
    return d;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// -----------------------------------------------------------------------------
// cache_way_array
//   Storage for the 2-way set-associative read cache: per set two valid bits,
//   two tags, two 64-bit blocks and one LRU bit (1 = way1 least recent).
//   Reads are asynchronous on `index`; all writes happen on the rising edge.
//   Valid and LRU bits clear asynchronously on rst (active low).
// Ports
//   clk, rst               clock, asynchronous active-low reset
//   index                  set addressed for both read and write
//   rd_valid/rd_tag/
//   rd_data/rd_lru         contents of the addressed set
//   fill_*                 write a whole block + tag into one way, mark valid
//   word_*                 overwrite one 32-bit word of one way
//   lru_wr_en/lru_val      update the LRU bit of the addressed set
// -----------------------------------------------------------------------------
module cache_way_array
  import mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_W-1:0]      index,
  output logic [1:0]              rd_valid,
  output logic [1:0][TAG_W-1:0]   rd_tag,
  output logic [1:0][63:0]        rd_data,
  output logic                    rd_lru,
  input  logic                    fill_en,
  input  logic                    fill_way,
  input  logic [TAG_W-1:0]        fill_tag,
  input  logic [63:0]             fill_data,
  input  logic                    word_wr_en,
  input  logic                    word_way,
  input  logic                    word_sel,
  input  logic [31:0]             word_data,
  input  logic                    lru_wr_en,
  input  logic                    lru_val
);

  logic [1:0]       valid_q [SETS];
  logic             lru_q   [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][2];
  logic [63:0]      data_q  [SETS][2];

  assign rd_valid   = valid_q[index];
  assign rd_lru     = lru_q[index];
  assign rd_tag[0]  = tag_q[index][0];
  assign rd_tag[1]  = tag_q[index][1];
  assign rd_data[0] = data_q[index][0];
  assign rd_data[1] = data_q[index][1];

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        lru_q[s]   <= 1'b0;
      end
    end else begin
      if (fill_en)   valid_q[index][fill_way] <= 1'b1;
      if (lru_wr_en) lru_q[index]             <= lru_val;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; a cleared valid bit
  // makes their contents irrelevant and keeps them mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index][fill_way]  <= fill_tag;
      data_q[index][fill_way] <= fill_data;
    end
    if (word_wr_en) begin
      if (word_sel) data_q[index][word_way][63:32] <= word_data;
      else          data_q[index][word_way][31:0]  <= word_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//   Sequencer between the MEM stage and the SRAM controller. Load hits in the
//   2-way read cache complete combinationally (ready=1 in the request cycle).
//   Load misses fetch the 64-bit block as two word reads and fill the LRU
//   victim. Stores are write-through, no-allocate; a store hit also patches
//   the cached word. The pipeline is frozen while ready=0.
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   MEM_R_EN / MEM_W_EN      load / store request, held until ready
//   ALU_Res / Val_Rm         byte address (word aligned) / store data
//   out / ready              load data (0 unless ready & MEM_R_EN) / done
//   sram_rd_en / sram_wr_en  word transfer request, held until sram_ready
//   sram_addr / sram_wdata   transfer byte address (MEM_BASE included) / data
//   sram_rdata / sram_ready  read data / one-cycle transfer-done pulse
// -----------------------------------------------------------------------------
module cache_controller
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] out,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  state_e      state_q, state_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word0_q, word0_d;

  addr_dec_t            dec;
  logic [1:0]           way_valid;
  logic [1:0][TAG_W-1:0] way_tag;
  logic [1:0][63:0]     way_data;
  logic                 way_lru;

  logic        hit0, hit1, hit, hit_way, victim_way;
  logic [63:0] hit_block;
  logic [31:0] hit_word;
  logic [31:0] block_addr;

  logic fill_en, word_wr_en, lru_wr_en, lru_val;

  assign dec = decode(ALU_Res[ADDR_W-1:2]);

  // Way0 wins if both ways ever matched.
  assign hit0      = way_valid[0] && (way_tag[0] == dec.tag);
  assign hit1      = way_valid[1] && (way_tag[1] == dec.tag) && !hit0;
  assign hit       = hit0 || hit1;
  assign hit_way   = hit1;
  assign hit_block = hit1 ? way_data[1] : way_data[0];
  assign hit_word  = dec.word ? hit_block[63:32] : hit_block[31:0];

  // An invalid way is always filled before anything is evicted.
  assign victim_way = !way_valid[0] ? 1'b0 :
                      !way_valid[1] ? 1'b1 : way_lru;

  // MEM_BASE is block aligned, so clearing the block offset of the absolute
  // address equals (relative block base + MEM_BASE).
  assign block_addr = {ALU_Res[31:3], 3'b000};

  cache_way_array u_ways (
    .clk        (clk),
    .rst        (rst),
    .index      (dec.index),
    .rd_valid   (way_valid),
    .rd_tag     (way_tag),
    .rd_data    (way_data),
    .rd_lru     (way_lru),
    .fill_en    (fill_en),
    .fill_way   (victim_way),
    .fill_tag   (dec.tag),
    .fill_data  ({sram_rdata, word0_q}),
    .word_wr_en (word_wr_en),
    .word_way   (hit_way),
    .word_sel   (dec.word),
    .word_data  (wdata_q),
    .lru_wr_en  (lru_wr_en),
    .lru_val    (lru_val)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    rd_en_d    = rd_en_q;
    wr_en_d    = wr_en_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word0_d    = word0_q;
    ready      = 1'b0;
    out        = 32'd0;
    fill_en    = 1'b0;
    word_wr_en = 1'b0;
    lru_wr_en  = 1'b0;
    lru_val    = way_lru;

    unique case (state_q)
      IDLE: begin
        if (MEM_R_EN) begin
          if (hit) begin
            ready     = 1'b1;
            out       = hit_word;
            lru_wr_en = 1'b1;
            lru_val   = ~hit_way;  // the other way becomes least recent
          end else begin
            state_d = FILL0;
            rd_en_d = 1'b1;
            addr_d  = block_addr;
          end
        end else if (MEM_W_EN) begin
          state_d = WRITE;
          wr_en_d = 1'b1;
          wdata_d = Val_Rm;
          addr_d  = ALU_Res;
        end else begin
          ready = 1'b1;
        end
      end

      FILL0: begin
        if (sram_ready) begin
          word0_d = sram_rdata;
          addr_d  = addr_q + 32'd4;
          state_d = FILL1;
        end
      end

      FILL1: begin
        if (sram_ready) begin
          fill_en   = 1'b1;
          lru_wr_en = 1'b1;
          lru_val   = ~way_lru;
          rd_en_d   = 1'b0;
          ready     = 1'b1;
          // Word1 is only on sram_rdata this cycle; bypass it to the pipeline.
          if (MEM_R_EN) out = dec.word ? sram_rdata : word0_q;
          state_d   = IDLE;
        end
      end

      WRITE: begin
        if (sram_ready) begin
          ready      = 1'b1;
          wr_en_d    = 1'b0;
          word_wr_en = hit;  // write-through, no allocate on a miss
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word0_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word0_q <= word0_d;
    end
  end

  assign sram_rd_en = rd_en_q;
  assign sram_wr_en = wr_en_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule
